seq_arith_add_mcycle: RTL and testbench

- Parametrised multi-cycle two's-complement adder. It is the sequential successor to the 8-bit combinational adder.
- Adds two NBITS operands CBITS bits per cycle, using a single narrow chunk adder and a rippled carry register.
- Returns the sum with carry-out and signed-overflow flags.
- Sits between producer and consumer stages on latency-insensitive val/rdy interfaces. Used where a full-width adder is too large or too slow.

---
 rtl/seq_arith_pkg.sv | 17 +
 rtl/seq_arith_chunk_add.sv | 23 ++
 rtl/seq_arith_add_mcycle.sv | 146 ++++++++++++++
 tb/tb_seq_arith_add_mcycle.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_arith_pkg.sv
// Shared types and elaboration helpers for the multi-cycle adder.
// Optional subtract mode is enabled by defining SEQ_ARITH_ADD_MCYCLE_SUB_EN.
package seq_arith_pkg;

    // Controller states: waiting for a request, rippling chunks, holding the result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // The operand width must split into a whole number of chunks.
    function automatic bit width_ok(input int nbits, input int cbits);
        return (cbits > 0) && (nbits >= cbits) && ((nbits % cbits) == 0);
    endfunction

endpackage

// File: rtl/seq_arith_chunk_add.sv
// Combinational W-bit adder slice with carry in and carry out.
// The multi-cycle adder reuses one of these for every chunk.
module seq_arith_chunk_add #(
    parameter int W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         cin_i,
    output logic [W-1:0] sum_o,
    output logic         cout_o
);

    logic [W:0] full_sum;

    // One extra bit captures the carry out of the slice.
    always_comb begin
        full_sum = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, cin_i};
    end

    assign sum_o  = full_sum[W-1:0];
    assign cout_o = full_sum[W];

endmodule

// File: rtl/seq_arith_add_mcycle.sv
// Multi-cycle two's-complement adder: NBITS operands are summed CBITS bits per
// clock through a single chunk adder and a rippled carry register.
// Request and response sides use val/rdy handshakes: a transfer happens on a
// rising clk edge where both val and rdy are high; a producer holds val (and
// its data) until the transfer, and rdy never depends on val.
// Defining SEQ_ARITH_ADD_MCYCLE_SUB_EN adds the op port (op=1: in0 - in1).
module seq_arith_add_mcycle
    import seq_arith_pkg::*;
#(
    parameter int NBITS = 32,
    parameter int CBITS = 8
) (
`ifdef SEQ_ARITH_ADD_MCYCLE_SUB_EN
    input  logic             op,
`endif
    input  logic             clk,
    input  logic             reset,
    input  logic             in_val,
    output logic             in_rdy,
    input  logic [NBITS-1:0] in0,
    input  logic [NBITS-1:0] in1,
    output logic             out_val,
    input  logic             out_rdy,
    output logic [NBITS-1:0] out,
    output logic             cout,
    output logic             ovf,
    output logic [1:0]       dbg_state
);

    localparam int NCHUNKS = NBITS / CBITS;
    localparam int CNT_W   = (NCHUNKS > 1) ? $clog2(NCHUNKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCHUNKS - 1);

    generate
        if (!width_ok(NBITS, CBITS)) begin : g_bad_width
            $error("seq_arith_add_mcycle: NBITS must be a multiple of CBITS");
        end
    endgenerate

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic [NBITS-1:0]   a_q, a_d;
    logic [NBITS-1:0]   b_q, b_d;      // effective second operand (inverted when subtracting)
    logic [NBITS-1:0]   out_q, out_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic [CBITS-1:0]   a_chunk;
    logic [CBITS-1:0]   b_chunk;
    logic [CBITS-1:0]   s_chunk;
    logic               c_chunk;

    // Select the operand chunks addressed by the counter.
    always_comb begin
        a_chunk = a_q[int'(cnt_q)*CBITS +: CBITS];
        b_chunk = b_q[int'(cnt_q)*CBITS +: CBITS];
    end

    seq_arith_chunk_add #(.W(CBITS)) u_chunk_add (
        .a_i    (a_chunk),
        .b_i    (b_chunk),
        .cin_i  (carry_q),
        .sum_o  (s_chunk),
        .cout_o (c_chunk)
    );

    // Next-state and datapath updates; every register holds unless its state acts.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        out_d   = out_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_val) begin
                    a_d     = in0;
                    b_d     = in1;
                    carry_d = 1'b0;
`ifdef SEQ_ARITH_ADD_MCYCLE_SUB_EN
                    if (op) begin
                        b_d     = ~in1;
                        carry_d = 1'b1;
                    end
`endif
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                out_d[int'(cnt_q)*CBITS +: CBITS] = s_chunk;
                carry_d = c_chunk;
                if (cnt_q == CNT_LAST) begin
                    cout_d  = c_chunk;
                    ovf_d   = (a_chunk[CBITS-1] == b_chunk[CBITS-1]) &&
                              (s_chunk[CBITS-1] != a_chunk[CBITS-1]);
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_rdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            out_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            out_q   <= out_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Handshake signals depend on state only.
    assign in_rdy    = (state_q == IDLE);
    assign out_val   = (state_q == DONE);
    assign out       = out_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_seq_arith_add_mcycle.sv
// Directed and randomised checks of seq_arith_add_mcycle with NBITS=32 and
// three chunk widths: instance 0 CBITS=8, instance 1 CBITS=32, instance 2 CBITS=4.
// Define SEQ_ARITH_ADD_MCYCLE_SUB_EN to include the subtract vectors.
module tb_seq_arith_add_mcycle;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset;
    int          cyc = 0;

    always #5 clk = ~clk;

    // Free-running cycle count used for latency measurements.
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic        in_val_v  [3];
    logic        in_rdy_v  [3];
    logic [31:0] in0_v     [3];
    logic [31:0] in1_v     [3];
    logic        out_val_v [3];
    logic        out_rdy_v [3];
    logic [31:0] out_v     [3];
    logic        cout_v    [3];
    logic        ovf_v     [3];
    logic [1:0]  dbg_v     [3];
`ifdef SEQ_ARITH_ADD_MCYCLE_SUB_EN
    logic        op_v      [3];
`endif

    for (genvar g = 0; g < 3; g++) begin : g_dut
        seq_arith_add_mcycle #(
            .NBITS (32),
            .CBITS ((g == 0) ? 8 : ((g == 1) ? 32 : 4))
        ) u_dut (
`ifdef SEQ_ARITH_ADD_MCYCLE_SUB_EN
            .op        (op_v[g]),
`endif
            .clk       (clk),
            .reset     (reset),
            .in_val    (in_val_v[g]),
            .in_rdy    (in_rdy_v[g]),
            .in0       (in0_v[g]),
            .in1       (in1_v[g]),
            .out_val   (out_val_v[g]),
            .out_rdy   (out_rdy_v[g]),
            .out       (out_v[g]),
            .cout      (cout_v[g]),
            .ovf       (ovf_v[g]),
            .dbg_state (dbg_v[g])
        );
    end

    // ---------------- scoreboard ----------------
    int          checks = 0;
    int          errors = 0;
    int          acc_cyc = 0;
    int          hs_cyc = 0;
    logic [33:0] exp_q[$];   // {ovf, cout, sum}

    function automatic int nch(input int k);
        return (k == 0) ? 4 : ((k == 1) ? 1 : 8);
    endfunction

    // Full-width reference: one 33-bit add of the effective operands.
    function automatic logic [33:0] ref_add(input logic [31:0] a, input logic [31:0] b, input logic op);
        logic [31:0] bb;
        logic [32:0] s;
        logic        v;
        bb = op ? ~b : b;
        s  = {1'b0, a} + {1'b0, bb} + {32'd0, op};
        v  = (a[31] == bb[31]) && (s[31] != a[31]);
        return {v, s[32], s[31:0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Present a request and return #1 after the accept edge.
    task automatic send(input int k, input logic [31:0] a, input logic [31:0] b,
                        input logic op, input int gap);
        int n;
        repeat (gap) begin @(posedge clk); #1; end
        in_val_v[k] = 1'b1;
        in0_v[k]    = a;
        in1_v[k]    = b;
`ifdef SEQ_ARITH_ADD_MCYCLE_SUB_EN
        op_v[k]     = op;
`else
        if (op) check("op_without_sub_build", 64'(op), 64'd0);
`endif
        n = 0;
        while (!in_rdy_v[k] && n < 100) begin @(posedge clk); #1; n++; end
        if (!in_rdy_v[k]) begin
            check("send_timeout", 64'd0, 64'd1);
            in_val_v[k] = 1'b0;
            return;
        end
        @(posedge clk); #1;
        acc_cyc     = cyc;
        in_val_v[k] = 1'b0;
        in0_v[k]    = $urandom;
        in1_v[k]    = $urandom;
`ifdef SEQ_ARITH_ADD_MCYCLE_SUB_EN
        op_v[k]     = ~op;
`endif
    endtask

    // Wait for the response, check latency and hold behaviour, then take it.
    task automatic recv(input int k, input int hold, input int lat);
        int n;
        logic [33:0] e;
        n = 0;
        while (!out_val_v[k] && n < 100) begin @(posedge clk); #1; n++; end
        if (!out_val_v[k]) begin
            check("recv_timeout", 64'd0, 64'd1);
            return;
        end
        check("latency", 64'(cyc - acc_cyc), 64'(lat));
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 64'd0, 64'd1);
            return;
        end
        e = exp_q.pop_front();
        for (int h = 0; h < hold; h++) begin
            check("hold_out", 64'(out_v[k]), 64'(e[31:0]));
            check("hold_in_rdy", 64'(in_rdy_v[k]), 64'd0);
            @(posedge clk); #1;
            check("hold_out_val", 64'(out_val_v[k]), 64'd1);
        end
        out_rdy_v[k] = 1'b1;
        check("sum", 64'(out_v[k]), 64'(e[31:0]));
        check("cout", 64'(cout_v[k]), 64'(e[32]));
        check("ovf", 64'(ovf_v[k]), 64'(e[33]));
        @(posedge clk); #1;
        hs_cyc       = cyc;
        out_rdy_v[k] = 1'b0;
        check("out_val_drop", 64'(out_val_v[k]), 64'd0);
        check("in_rdy_back", 64'(in_rdy_v[k]), 64'd1);
    endtask

    task automatic check_reset_state(input int k);
        check("rst_out_val", 64'(out_val_v[k]), 64'd0);
        check("rst_in_rdy", 64'(in_rdy_v[k]), 64'd1);
        check("rst_out", 64'(out_v[k]), 64'd0);
        check("rst_cout", 64'(cout_v[k]), 64'd0);
        check("rst_ovf", 64'(ovf_v[k]), 64'd0);
        check("rst_state", 64'(dbg_v[k]), 64'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #300000;
        $display("FAIL watchdog simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [31:0] ra, rb;
        logic        rop;
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_val_v[k]  = 1'b0;
            out_rdy_v[k] = 1'b0;
            in0_v[k]     = '0;
            in1_v[k]     = '0;
`ifdef SEQ_ARITH_ADD_MCYCLE_SUB_EN
            op_v[k]      = 1'b0;
`endif
        end
        #1;
        for (int k = 0; k < 3; k++) check_reset_state(k);
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        @(posedge clk); #1;

        // Basic add and cross-chunk carry ripple.
        exp_q.push_back({1'b0, 1'b0, 32'd55});
        send(0, 32'd42, 32'd13, 1'b0, 0);
        recv(0, 0, 4);
        exp_q.push_back({1'b0, 1'b0, 32'h0000_0100});
        send(0, 32'h0000_00FF, 32'd1, 1'b0, 0);
        recv(0, 0, 4);

        // Overflow and wrap corners.
        exp_q.push_back({1'b1, 1'b0, 32'h8000_0000});
        send(0, 32'h7FFF_FFFF, 32'd1, 1'b0, 0);
        recv(0, 0, 4);
        exp_q.push_back({1'b0, 1'b1, 32'h0000_0000});
        send(0, 32'hFFFF_FFFF, 32'd1, 1'b0, 0);
        recv(0, 0, 4);
        exp_q.push_back({1'b1, 1'b1, 32'h7FFF_FFFF});
        send(0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
        recv(0, 0, 4);

        // Same corners on the single-cycle and 4-bit-chunk builds.
        exp_q.push_back({1'b1, 1'b1, 32'h7FFF_FFFF});
        send(1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
        recv(1, 0, 1);
        exp_q.push_back({1'b0, 1'b0, 32'h0000_0100});
        send(2, 32'h0000_00FF, 32'd1, 1'b0, 1);
        recv(2, 2, 8);

        // Backpressure: a waiting request is ignored until the DUT is idle again.
        exp_q.push_back({1'b0, 1'b0, 32'd11});
        send(0, 32'd5, 32'd6, 1'b0, 0);
        in_val_v[0] = 1'b1;
        in0_v[0]    = 32'd7;
        in1_v[0]    = 32'd8;
        exp_q.push_back({1'b0, 1'b0, 32'd15});
        recv(0, 5, 4);
        send(0, 32'd7, 32'd8, 1'b0, 0);
        check("accept_next_idle", 64'(acc_cyc), 64'(hs_cyc + 1));
        recv(0, 0, 4);

        // Reset two cycles into a computation.
        send(0, 32'h1111_1111, 32'h2222_2222, 1'b0, 0);
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check_reset_state(0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            check("no_stale_resp", 64'(out_val_v[0]), 64'd0);
        end
        exp_q.push_back({1'b0, 1'b0, 32'd127});
        send(0, 32'd100, 32'd27, 1'b0, 0);
        recv(0, 0, 4);

`ifdef SEQ_ARITH_ADD_MCYCLE_SUB_EN
        // Subtract mode.
        exp_q.push_back({1'b0, 1'b0, 32'hFFFF_FFE3});
        send(0, 32'd13, 32'd42, 1'b1, 0);
        recv(0, 0, 4);
        exp_q.push_back({1'b1, 1'b1, 32'h7FFF_FFFF});
        send(0, 32'h8000_0000, 32'd1, 1'b1, 0);
        recv(0, 0, 4);
        exp_q.push_back({1'b0, 1'b1, 32'd0});
        send(2, 32'd42, 32'd42, 1'b1, 0);
        recv(2, 1, 8);
`endif

        // Random pairs with random request/response gaps on every build.
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 20; i++) begin
                ra = $urandom;
                rb = $urandom;
`ifdef SEQ_ARITH_ADD_MCYCLE_SUB_EN
                rop = 1'($urandom_range(0, 1));
`else
                rop = 1'b0;
`endif
                exp_q.push_back(ref_add(ra, rb, rop));
                send(k, ra, rb, rop, $urandom_range(0, 3));
                recv(k, $urandom_range(0, 3), nch(k));
            end
        end

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
